// File: rtl/mvau_weight_loader_if.sv
// rtl/mvau_weight_loader_if.sv - weight stream and PE weight-memory write bundle
//
// Carries the incoming weight stream (s_axis_tdata/tvalid/tready) and the
// shared write port to the PE weight memories (wmem_we/waddr/wdata).
//   slave  : the loader; consumes the stream and drives the memory writes
//   master : the stream source / memory side; drives the stream and observes writes
interface mvau_weight_loader_if #(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int PE           = 2,
    parameter int WMEM_ADDR_BW = 4
);
    logic [SIMD*TW-1:0]      s_axis_tdata;
    logic                    s_axis_tvalid;
    logic                    s_axis_tready;
    logic [PE-1:0]           wmem_we;
    logic [WMEM_ADDR_BW-1:0] wmem_waddr;
    logic [SIMD*TW-1:0]      wmem_wdata;

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        output s_axis_tready,
        output wmem_we,
        output wmem_waddr,
        output wmem_wdata
    );

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        input  s_axis_tready,
        input  wmem_we,
        input  wmem_waddr,
        input  wmem_wdata
    );
endinterface

// File: rtl/mvau_weight_loader.sv
// rtl/mvau_weight_loader.sv - streams weight words into PE-interleaved weight memories
//
// Ports:
//   aclk        clock, rising edge
//   aresetn     synchronous active-low reset
//   start       single-cycle load request (honoured only in IDLE)
//   bus         mvau_weight_loader_if.slave: weight stream in, memory write port out
//   busy        high while loading
//   load_done   one-cycle pulse in the cycle the final word is written
//   wload_chksum  XOR of all words of the current load (only with MVAU_WLOAD_CHKSUM_EN)
//
// Optional feature macro: MVAU_WLOAD_CHKSUM_EN
//
// Word k of a load goes to PE (k mod PE) at address (k div PE). Writes are
// registered, so each one appears the cycle after its handshake.
module mvau_weight_loader #(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int PE           = 2,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   start,
    mvau_weight_loader_if.slave    bus,
    output logic                   busy,
    output logic                   load_done
`ifdef MVAU_WLOAD_CHKSUM_EN
    ,
    output logic [SIMD*TW-1:0]     wload_chksum
`endif
);

    localparam int DW    = SIMD * TW;
    localparam int PE_BW = (PE > 1) ? $clog2(PE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PE_BW-1:0]        pe_cnt_q, pe_cnt_d;
    logic [WMEM_ADDR_BW-1:0] addr_cnt_q, addr_cnt_d;
    logic [PE-1:0]           we_q, we_d;
    logic [WMEM_ADDR_BW-1:0] waddr_q, waddr_d;
    logic [DW-1:0]           wdata_q, wdata_d;
`ifdef MVAU_WLOAD_CHKSUM_EN
    logic [DW-1:0]           chk_q, chk_d;
`endif

    logic hs;
    logic pe_last;
    logic addr_last;

    // tready comes straight from the state register, so there is no path
    // from tvalid back to tready.
    assign bus.s_axis_tready = (state_q == LOAD);
    assign hs        = bus.s_axis_tvalid && (state_q == LOAD);
    assign pe_last   = (pe_cnt_q == PE_BW'(PE - 1));
    assign addr_last = (addr_cnt_q == WMEM_ADDR_BW'(WMEM_DEPTH - 1));

    always_comb begin
        state_d    = state_q;
        pe_cnt_d   = pe_cnt_q;
        addr_cnt_d = addr_cnt_q;
        we_d       = '0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
`ifdef MVAU_WLOAD_CHKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    pe_cnt_d   = '0;
                    addr_cnt_d = '0;
`ifdef MVAU_WLOAD_CHKSUM_EN
                    chk_d      = '0;
`endif
                end
            end
            LOAD: begin
                if (hs) begin
                    we_d    = PE'(1) << pe_cnt_q;
                    waddr_d = addr_cnt_q;
                    wdata_d = bus.s_axis_tdata;
`ifdef MVAU_WLOAD_CHKSUM_EN
                    chk_d   = chk_q ^ bus.s_axis_tdata;
`endif
                    if (pe_last) begin
                        pe_cnt_d = '0;
                        if (addr_last) begin
                            state_d = DONE;
                        end else begin
                            addr_cnt_d = addr_cnt_q + 1'b1;
                        end
                    end else begin
                        pe_cnt_d = pe_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            pe_cnt_q   <= '0;
            addr_cnt_q <= '0;
            we_q       <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
`ifdef MVAU_WLOAD_CHKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pe_cnt_q   <= pe_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
`ifdef MVAU_WLOAD_CHKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    // A write registered from the last handshake before an aborting reset
    // must not reach the memories, so the enable is masked while reset is low.
    assign bus.wmem_we    = we_q & {PE{aresetn}};
    assign bus.wmem_waddr = waddr_q;
    assign bus.wmem_wdata = wdata_q;
    assign busy           = (state_q == LOAD);
    assign load_done      = (state_q == DONE);
`ifdef MVAU_WLOAD_CHKSUM_EN
    assign wload_chksum   = chk_q;
`endif

endmodule
